ccr_sequencer: RTL and testbench
================================

CCR_SEQUENCER -- requirements
Module: ccr_sequencer

Interface
REQ-001 SHALL provide parameter STACK_DEPTH, default 4, giving the number of CCR save-stack entries (legal values 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 asserts).
REQ-004 SHALL have port alu_valid, input, 1 bit: an ALU flag update is requested.
REQ-005 SHALL have port alu_flags, input, 3 bits: new flags {carry, negative, zero}.
REQ-006 SHALL have port setc and port clrc, each input, 1 bit: set or clear the carry flag.
REQ-007 SHALL have port int_req, input, 1 bit: interrupt entry; push CCR onto the save stack.
REQ-008 SHALL have port rti_req, input, 1 bit: return from interrupt; pop the save stack into CCR.
REQ-009 SHALL have port func_code, input, 3 bits: selects the bit driven on chosen_bit.
REQ-010 SHALL have port ccr, output, 4 bits: current {1, carry, negative, zero}.
REQ-011 SHALL have port chosen_bit, output, 1 bit: the CCR bit selected by func_code.
REQ-012 SHALL have ports busy, stack_empty and stack_full, each output, 1 bit: status indicators.
REQ-013 SHALL have port stack_err, output, 1 bit: sticky indicator of a push overflow or pop underflow.

Function
REQ-014 SHALL implement an FSM with states IDLE, SAVE and RESTORE; busy=1 in SAVE and RESTORE.
REQ-015 SHALL, in IDLE, transition on rti_req to RESTORE, otherwise on int_req to SAVE; rti_req has priority when both are asserted.
REQ-016 SHALL, in SAVE, write CCR into stack[sp], increment sp, clear ccr[2:0], and return to IDLE after exactly 1 cycle.
REQ-017 SHALL, in RESTORE, decrement sp, load CCR from the popped entry, and return to IDLE after exactly 1 cycle.
REQ-018 SHALL ignore alu_valid, setc, clrc, int_req and rti_req while busy=1; there is no queuing, so the requester must hold or re-issue.
REQ-019 SHALL, in IDLE with no int/rti, apply the highest-priority update at the next edge, in order: clrc (carry=0), setc (carry=1), alu_valid (ccr[2:0]=alu_flags).
REQ-020 SHALL let clrc win when setc and clrc are asserted together, and leave negative and zero unchanged in that case.
REQ-021 SHALL hold ccr[3]=1 at all times.
REQ-022 SHALL drive chosen_bit as ccr[func_code] for func_code 0..3, and ccr[3] for func_code 4..7.
REQ-023 SHALL set stack_empty=1 when sp=0, and stack_full=1 when sp=STACK_DEPTH.
REQ-024 SHALL, on int_req when full, enter SAVE, leave stack and sp unchanged, still clear flags, and set stack_err.
REQ-025 SHALL, on rti_req when empty, enter RESTORE, leave CCR and sp unchanged, and set stack_err.
REQ-026 SHALL clear stack_err only on reset.
REQ-027 SHALL use sp of width clog2(STACK_DEPTH+1), with no wrap-around.

Reset
REQ-028 SHALL, on reset=0, immediately force state=IDLE, ccr=4'b1000, sp=0, busy=0, stack_err=0, stack_empty=1, stack_full=0 and chosen_bit=ccr[func_code].
REQ-029 SHALL leave stack contents undefined after reset; they are never read while empty.
REQ-030 SHALL, when reset asserts during SAVE or RESTORE, abort the operation with no partial push or pop visible after reset.

Configuration
REQ-031 SHALL, with CCR_FWD_EN defined, drive ccr and chosen_bit combinationally from the pending IDLE update (alu, setc or clrc), giving 0-cycle visibility; SAVE and RESTORE are not forwarded.
REQ-032 SHALL, with CCR_FWD_EN undefined, drive ccr and chosen_bit from registered state only, giving 1-cycle latency.

Verification
REQ-033 SHALL cover: reset, then alu_valid=1 with alu_flags=3'b101 -> ccr=4'b1101 after 1 edge; func_code=2 -> chosen_bit=1.
REQ-034 SHALL cover: setc=1 and clrc=1 together with ccr=4'b1110 -> ccr=4'b1010.
REQ-035 SHALL cover: ccr=4'b1011, int_req for 1 cycle -> busy=1 for 1 cycle, ccr=4'b1000, sp=1; then rti_req -> ccr=4'b1011, stack_empty=1.
REQ-036 SHALL cover: 5 pushes with STACK_DEPTH=4 -> stack_full=1 after the 4th, stack_err=1 after the 5th, and 4 pops restore values in LIFO order.
REQ-037 SHALL cover: rti_req while empty -> stack_err=1 and ccr unchanged; alu_valid during busy -> ignored.
REQ-038 SHALL cover: reset asserted mid-SAVE -> ccr=4'b1000, sp=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ccr_sequencer.sv
// Condition-code register with an interrupt save/restore stack and a 3-state sequencer.
// Define CCR_FWD_EN to forward pending IDLE flag updates combinationally onto ccr/chosen_bit.
module ccr_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    input  logic [2:0] alu_flags,
    input  logic       setc,
    input  logic       clrc,
    input  logic       int_req,
    input  logic       rti_req,
    input  logic [2:0] func_code,
    output logic [3:0] ccr,
    output logic       chosen_bit,
    output logic       busy,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [2:0]      r_flags;
    logic [SP_W-1:0] r_sp;
    logic            r_err;
    logic [2:0]      r_stack [0:STACK_DEPTH-1];

    logic [2:0]       w_upd_flags;
    logic [2:0]       w_ccr_flags;
    logic [SP_W-1:0]  w_sp_dec;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_full;
    logic             w_empty;

    assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_sp_dec = r_sp - SP_W'(1);
    assign w_wr_idx = r_sp[IDX_W-1:0];
    assign w_rd_idx = w_sp_dec[IDX_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                if (rti_req)      w_next_state = RESTORE;
                else if (int_req) w_next_state = SAVE;
                else              w_next_state = IDLE;
            end
            SAVE:    w_next_state = IDLE;
            RESTORE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    // Flag update that IDLE would commit at the next edge; clrc beats setc beats alu_valid.
    always_comb begin
        w_upd_flags = r_flags;
        if (r_state == IDLE && !rti_req && !int_req) begin
            if (clrc)           w_upd_flags[2] = 1'b0;
            else if (setc)      w_upd_flags[2] = 1'b1;
            else if (alu_valid) w_upd_flags    = alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 3'b000;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_flags <= w_upd_flags;
                SAVE: begin
                    r_flags <= 3'b000;
                    if (w_full) r_err <= 1'b1;
                    else        r_sp  <= r_sp + SP_W'(1);
                end
                RESTORE: begin
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_sp    <= w_sp_dec;
                        r_flags <= r_stack[w_rd_idx];
                    end
                end
                default: r_flags <= r_flags;
            endcase
        end
    end

    // NOTE: stack storage has no reset; entries above sp are never read, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (r_state == SAVE && !w_full) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

`ifdef CCR_FWD_EN
    assign w_ccr_flags = w_upd_flags;
`else
    assign w_ccr_flags = r_flags;
`endif

    assign ccr         = {1'b1, w_ccr_flags};
    assign chosen_bit  = func_code[2] ? 1'b1 : ccr[func_code[1:0]];
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_err;

endmodule

// File: tb/tb_ccr_sequencer.sv
// Self-checking bench for ccr_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_ccr_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       alu_valid;
    logic [2:0] alu_flags;
    logic       setc;
    logic       clrc;
    logic       int_req;
    logic       rti_req;
    logic [2:0] func_code;
    logic [3:0] ccr;
    logic       chosen_bit;
    logic       busy;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    ccr_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_flags  (alu_flags),
        .setc       (setc),
        .clrc       (clrc),
        .int_req    (int_req),
        .rti_req    (rti_req),
        .func_code  (func_code),
        .ccr        (ccr),
        .chosen_bit (chosen_bit),
        .busy       (busy),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: flags, a LIFO queue, and the operation being carried out this cycle
    // (0 none, 1 push, 2 pop). Requests take effect one cycle after they are accepted.
    logic [2:0] m_flags;
    logic [2:0] m_q[$];
    int         m_op;
    bit         m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags = 3'b000;
            m_q.delete();
            m_op    = 0;
            m_err   = 1'b0;
        end else if (m_op == 1) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_flags);
            else                    m_err = 1'b1;
            m_flags = 3'b000;
            m_op    = 0;
        end else if (m_op == 2) begin
            if (m_q.size() > 0) m_flags = m_q.pop_back();
            else                m_err   = 1'b1;
            m_op = 0;
        end else if (rti_req) begin
            m_op = 2;
        end else if (int_req) begin
            m_op = 1;
        end else if (clrc) begin
            m_flags[2] = 1'b0;
        end else if (setc) begin
            m_flags[2] = 1'b1;
        end else if (alu_valid) begin
            m_flags = alu_flags;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_chosen(input logic [3:0] c, input logic [2:0] fc);
        logic [3:0] v;
        v = c;
        return (fc > 3'd3) ? 1'b1 : v[fc[1:0]];
    endfunction

    // Compare process: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ccr",   ccr,                {1'b1, m_flags});
            check("m_chosen", {3'b0, chosen_bit}, {3'b0, exp_chosen({1'b1, m_flags}, func_code)});
            check("m_busy",  {3'b0, busy},        {3'b0, (m_op != 0)});
            check("m_empty", {3'b0, stack_empty}, {3'b0, (m_q.size() == 0)});
            check("m_full",  {3'b0, stack_full},  {3'b0, (m_q.size() == DEPTH)});
            check("m_err",   {3'b0, stack_err},   {3'b0, m_err});
        end
    end

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_flags = 3'b000;
        setc      = 1'b0;
        clrc      = 1'b0;
        int_req   = 1'b0;
        rti_req   = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [2:0] f);
        idle_inputs();
        alu_valid = 1'b1;
        alu_flags = f;
        next();
        idle_inputs();
    endtask

    task automatic push();
        idle_inputs();
        int_req = 1'b1;
        next();
        idle_inputs();
        next();
    endtask

    task automatic pop();
        idle_inputs();
        rti_req = 1'b1;
        next();
        idle_inputs();
        next();
    endtask

    logic [2:0] pv [0:3];

    initial begin
        pv[0] = 3'b001; pv[1] = 3'b010; pv[2] = 3'b100; pv[3] = 3'b110;
        reset = 1'b0;
        func_code = 3'd0;
        idle_inputs();
        repeat (2) next();

        check("rst_ccr",   ccr,                4'b1000);
        check("rst_busy",  {3'b0, busy},        4'd0);
        check("rst_empty", {3'b0, stack_empty}, 4'd1);
        check("rst_full",  {3'b0, stack_full},  4'd0);
        check("rst_err",   {3'b0, stack_err},   4'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // ALU load, chosen_bit on func_code 2
        func_code = 3'd2;
        load_flags(3'b101);
        check("alu_ccr",    ccr,               4'b1101);
        check("alu_chosen", {3'b0, chosen_bit}, 4'd1);

        // setc+clrc together: clrc wins, N/Z untouched
        load_flags(3'b110);
        setc = 1'b1; clrc = 1'b1;
        next();
        idle_inputs();
        check("sc_cc_ccr", ccr, 4'b1010);

        // single save/restore round trip
        load_flags(3'b011);
        int_req = 1'b1;
        next();
        int_req = 1'b0;
        check("save_busy", {3'b0, busy}, 4'd1);
        next();
        check("save_busy_off", {3'b0, busy},        4'd0);
        check("save_ccr",      ccr,                 4'b1000);
        check("save_sp1",      {2'b0, stack_empty, stack_full}, 4'b0000);
        rti_req = 1'b1;
        next();
        rti_req = 1'b0;
        check("rest_busy", {3'b0, busy}, 4'd1);
        next();
        check("rest_ccr",   ccr,                 4'b1011);
        check("rest_empty", {3'b0, stack_empty}, 4'd1);

        // fill to depth, overflow, then LIFO drain
        for (int k = 0; k < DEPTH; k++) begin
            load_flags(pv[k]);
            push();
        end
        check("fill_full", {3'b0, stack_full}, 4'd1);
        check("fill_err",  {3'b0, stack_err},  4'd0);
        load_flags(3'b111);
        push();
        check("ovf_err",  {3'b0, stack_err},  4'd1);
        check("ovf_full", {3'b0, stack_full}, 4'd1);
        check("ovf_ccr",  ccr,                4'b1000);
        for (int k = 0; k < DEPTH; k++) begin
            pop();
            check($sformatf("lifo_%0d", k), ccr, {1'b1, pv[DEPTH-1-k]});
        end
        check("drain_empty", {3'b0, stack_empty}, 4'd1);

        // underflow with alu_valid presented while busy
        load_flags(3'b011);
        rti_req = 1'b1;
        next();
        idle_inputs();
        alu_valid = 1'b1;
        alu_flags = 3'b111;
        next();
        idle_inputs();
        check("unf_ccr", ccr,               4'b1011);
        check("unf_err", {3'b0, stack_err}, 4'd1);

        // reset asserted mid-SAVE takes effect without a clock edge
        load_flags(3'b101);
        int_req = 1'b1;
        next();
        int_req = 1'b0;
        check("mid_busy", {3'b0, busy}, 4'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_ccr",   ccr,                 4'b1000);
        check("mid_busy0", {3'b0, busy},        4'd0);
        check("mid_empty", {3'b0, stack_empty}, 4'd1);
        check("mid_err",   {3'b0, stack_err},   4'd0);
        reset = 1'b1;
        next();
        check("mid_nopush", {3'b0, stack_empty}, 4'd1);

        // randomized traffic, checked by the compare process every cycle
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 15);
            rti_req   = (r == 2 || r == 3);
            int_req   = (r == 0 || r == 1 || r == 4);
            setc      = ($urandom_range(0, 5) == 0);
            clrc      = ($urandom_range(0, 5) == 0);
            alu_valid = $urandom_range(0, 1) == 1;
            alu_flags = 3'($urandom_range(0, 7));
            func_code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                #2 reset = 1'b1;
            end
            next();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
